// File: rtl/cache_assoc_ctrl_pkg.sv
// ============================================================================
// Package : cache_assoc_ctrl_pkg
// Brief   : Shared state encodings, default widths and clog2 helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_assoc_ctrl_pkg;

    localparam int c_DEF_DATA_W  = 8;
    localparam int c_DEF_ADDR_W  = 8;
    localparam int c_DEF_ENTRIES = 4;
    localparam int c_DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MISS_RD = 3'd2,
        ST_FILL    = 3'd3,
        ST_WR_THRU = 3'd4,
        ST_RESP    = 3'd5
    } cache_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_assoc_ctrl_if.sv
// ============================================================================
// Interface : cache_assoc_ctrl_if
// Brief     : CPU-side and RAM-side handshake bundle of the cache controller.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface cache_assoc_ctrl_if
    import cache_assoc_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cache_hit;
    logic              flush;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    // slave: the cache controller; master: the CPU/RAM environment around it
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, ram_rdata, ram_ack,
        output cpu_rdata, cpu_ack, cache_hit, ram_req, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, ram_rdata, ram_ack,
        input  cpu_rdata, cpu_ack, cache_hit, ram_req, ram_we, ram_addr, ram_wdata
    );

endinterface

`default_nettype wire

// File: rtl/cache_assoc_ctrl_lru_tracker.sv
// ============================================================================
// Module : cache_lru_tracker
// Brief  : True-LRU age tracker with invalid-first victim selection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_lru_tracker
    import cache_assoc_ctrl_pkg::*;
#(
    parameter int ENTRIES = c_DEF_ENTRIES,
    parameter int IDX_W   = clog2(ENTRIES)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_clear,
    input  wire logic               i_touch_en,
    input  wire logic [IDX_W-1:0]   i_touch_idx,
    input  wire logic [ENTRIES-1:0] i_valid,
    output logic      [IDX_W-1:0]   o_victim_idx
);

    logic [IDX_W-1:0] r_age [ENTRIES];
    logic             w_found_inv;
    logic [IDX_W-1:0] w_inv_idx;
    logic [IDX_W-1:0] w_old_idx;

    // Ages form a permutation of 0..ENTRIES-1; 0 is most recently used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) r_age[i] <= IDX_W'(i);
        end else if (i_clear) begin
            for (int i = 0; i < ENTRIES; i++) r_age[i] <= IDX_W'(i);
        end else if (i_touch_en) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (IDX_W'(i) == i_touch_idx)
                    r_age[i] <= '0;
                else if (r_age[i] < r_age[i_touch_idx])
                    r_age[i] <= r_age[i] + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_found_inv = 1'b0;
        w_inv_idx   = '0;
        w_old_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!i_valid[i] && !w_found_inv) begin
                w_found_inv = 1'b1;
                w_inv_idx   = IDX_W'(i);
            end
            if (r_age[i] == IDX_W'(ENTRIES - 1))
                w_old_idx = IDX_W'(i);
        end
    end

    assign o_victim_idx = w_found_inv ? w_inv_idx : w_old_idx;

endmodule

`default_nettype wire

// File: rtl/cache_assoc_ctrl.sv
// ============================================================================
// Module : cache_assoc_ctrl
// Brief  : Fully-associative write-through, no-write-allocate cache controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_assoc_ctrl
    import cache_assoc_ctrl_pkg::*;
#(
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int ENTRIES = c_DEF_ENTRIES,
    parameter int CNT_W   = c_DEF_CNT_W
) (
    input  wire logic                      g_clk,
    input  wire logic                      g_clr,
    cache_assoc_ctrl_if.slave              bus,
    output logic [clog2(ENTRIES)-1:0]      lru_idx,
    output logic [2:0]                     ch_state,
    output logic [CNT_W-1:0]               hit_cnt,
    output logic [CNT_W-1:0]               miss_cnt
);

    localparam int IDX_W = clog2(ENTRIES);

    cache_state_e      r_state;
    cache_state_e      w_next;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_hit;
    logic              r_cache_hit;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic [ENTRIES-1:0] r_valid;
    logic [ADDR_W-1:0]  r_tag  [ENTRIES];
    logic [DATA_W-1:0]  r_data [ENTRIES];

    logic              w_hit;
    logic [IDX_W-1:0]  w_hit_idx;
    logic [IDX_W-1:0]  w_victim;
    logic              w_touch_en;
    logic [IDX_W-1:0]  w_touch_idx;
    logic              w_clear;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == r_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_clear     = (r_state == ST_IDLE) && bus.flush;
    assign w_touch_en  = ((r_state == ST_LOOKUP) && w_hit) || (r_state == ST_FILL);
    assign w_touch_idx = (r_state == ST_FILL) ? w_victim : w_hit_idx;

    cache_lru_tracker #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_lru (
        .clk          (g_clk),
        .rst          (g_clr),
        .i_clear      (w_clear),
        .i_touch_en   (w_touch_en),
        .i_touch_idx  (w_touch_idx),
        .i_valid      (r_valid),
        .o_victim_idx (w_victim)
    );

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // RAM strobes decode straight from state so an async clear drops them at once.
    always_comb begin
        w_next      = r_state;
        bus.ram_req = 1'b0;
        bus.ram_we  = 1'b0;
        bus.cpu_ack = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.flush && bus.cpu_req) w_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (r_we)       w_next = ST_WR_THRU;
                else if (w_hit) w_next = ST_RESP;
                else            w_next = ST_MISS_RD;
            end
            ST_MISS_RD: begin
                bus.ram_req = 1'b1;
                if (bus.ram_ack) w_next = ST_FILL;
            end
            ST_FILL: w_next = ST_RESP;
            ST_WR_THRU: begin
                bus.ram_req = 1'b1;
                bus.ram_we  = 1'b1;
                if (bus.ram_ack) w_next = ST_RESP;
            end
            ST_RESP: begin
                bus.cpu_ack = 1'b1;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_hit       <= 1'b0;
            r_cache_hit <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_valid     <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.flush) begin
                        r_valid <= '0;
                    end else if (bus.cpu_req) begin
                        r_addr  <= bus.cpu_addr;
                        r_we    <= bus.cpu_we;
                        r_wdata <= bus.cpu_wdata;
                    end
                end
                ST_LOOKUP: begin
                    r_hit <= w_hit;
                    if (w_hit) begin
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        if (r_we) begin
                            r_data[w_hit_idx] <= r_wdata;
                        end else begin
                            r_rdata     <= r_data[w_hit_idx];
                            r_cache_hit <= 1'b1;
                        end
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                    end
                end
                ST_MISS_RD: begin
                    if (bus.ram_ack) r_rdata <= bus.ram_rdata;
                end
                ST_FILL: begin
                    r_tag[w_victim]   <= r_addr;
                    r_data[w_victim]  <= r_rdata;
                    r_valid[w_victim] <= 1'b1;
                    r_cache_hit       <= 1'b0;
                end
                ST_WR_THRU: begin
                    if (bus.ram_ack) r_cache_hit <= r_hit;
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;
    assign bus.cpu_rdata = r_rdata;
    assign bus.cache_hit = r_cache_hit;

    assign lru_idx  = w_victim;
    assign ch_state = r_state;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

`default_nettype wire
